// File: rtl/aes_shiftrows_unit.sv
`default_nettype none
// ============================================================================
//  Module      : aes_shiftrows_unit
//  Description : Handshaked ShiftRows / InvShiftRows stage for Rijndael with
//                Nb = 4, 6 or 8 columns. The direction is selected per block.
//                A 2-entry registered output buffer gives 1-cycle latency,
//                full throughput and lossless backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_shiftrows_unit #(
    parameter int NB = 4,
    parameter int BW = 32 * NB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mode,
    input  logic [BW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_mode,
    output logic [BW-1:0] out_data,
    output logic [1:0]    occupancy
);

    // Rows 2 and 3 shift further for the 256-bit block.
    localparam int c_SHIFT2 = (NB == 8) ? 3 : 2;
    localparam int c_SHIFT3 = (NB == 8) ? 4 : 3;

    // Reject unsupported geometries at elaboration time.
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shiftrows_unit: NB must be 4, 6 or 8");
    end
    if (BW != 32 * NB) begin : g_bad_bw
        $error("aes_shiftrows_unit: BW is derived from NB and must not be overridden");
    end

    logic [BW-1:0] w_fwd;
    logic [BW-1:0] w_inv;
    logic [BW-1:0] w_perm;
    logic          w_accept;
    logic          w_pop;
    logic [1:0]    w_next_count;

    logic [1:0]    r_count;
    logic          r_in_ready;
    logic          r_head_mode;
    logic [BW-1:0] r_head_data;
    logic          r_tail_mode;
    logic [BW-1:0] r_tail_data;

    // Pure byte routing: each output byte picks its source column within the
    // same row, wrapping modulo NB.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int c_SHIFT = (r == 0) ? 0 :
                                     (r == 1) ? 1 :
                                     (r == 2) ? c_SHIFT2 : c_SHIFT3;
            localparam int c_FSRC  = (c + c_SHIFT) % NB;
            localparam int c_ISRC  = (c - c_SHIFT + NB) % NB;
            assign w_fwd[BW-1-8*(4*c+r) -: 8] = in_data[BW-1-8*(4*c_FSRC+r) -: 8];
            assign w_inv[BW-1-8*(4*c+r) -: 8] = in_data[BW-1-8*(4*c_ISRC+r) -: 8];
        end
    end

    assign w_perm   = in_mode ? w_inv : w_fwd;
    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = (r_count != 2'd0) && out_ready;

    // Next buffer fill level from the accept/pop pair.
    always_comb begin
        w_next_count = r_count;
        case ({w_accept, w_pop})
            2'b10:   w_next_count = r_count + 2'd1;
            2'b01:   w_next_count = r_count - 2'd1;
            default: w_next_count = r_count;
        endcase
    end

    // Two-entry FIFO held as head/tail registers; head always drives the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= 2'd0;
            r_in_ready  <= 1'b1;
            r_head_mode <= 1'b0;
            r_head_data <= '0;
            r_tail_mode <= 1'b0;
            r_tail_data <= '0;
        end else begin
            r_count    <= w_next_count;
            r_in_ready <= (w_next_count < 2'd2);
            if (r_count == 2'd0) begin
                if (w_accept) begin
                    r_head_mode <= in_mode;
                    r_head_data <= w_perm;
                end
            end else if (r_count == 2'd1) begin
                if (w_accept && w_pop) begin
                    // Current head leaves this edge; the new block replaces it.
                    r_head_mode <= in_mode;
                    r_head_data <= w_perm;
                end else if (w_accept) begin
                    r_tail_mode <= in_mode;
                    r_tail_data <= w_perm;
                end
            end else begin
                // Full: no accept possible, a pop promotes the tail.
                if (w_pop) begin
                    r_head_mode <= r_tail_mode;
                    r_head_data <= r_tail_data;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_mode  = r_head_mode;
    assign out_data  = r_head_data;
    assign occupancy = r_count;

endmodule
`default_nettype wire

// File: tb/tb_aes_shiftrows_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_shiftrows_unit
//  Description : Scoreboard bench running NB=4, 6 and 8 instances in lockstep
//                against a byte-array reference model of (Inv)ShiftRows.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_shiftrows_unit;

    typedef struct {
        logic         mode;
        logic [255:0] e4;
        logic [255:0] e6;
        logic [255:0] e8;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_mode;
    logic         out_ready;
    logic [127:0] in_d4;
    logic [191:0] in_d6;
    logic [255:0] in_d8;

    logic         rdy4, rdy6, rdy8, ov4, ov6, ov8, om4, om6, om8;
    logic [127:0] od4;
    logic [191:0] od6;
    logic [255:0] od8;
    logic [1:0]   occ4, occ6, occ8;

    int           checks = 0;
    int           errors = 0;
    int           rmode  = 0;
    bit           cap_en = 1'b0;
    exp_t         sb[$];
    exp_t         mon_e;
    logic [255:0] cap4[$];
    logic [255:0] cap6[$];
    logic [255:0] cap8[$];
    logic [255:0] origq[$];

    aes_shiftrows_unit #(.NB(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_mode(in_mode),
        .in_data(in_d4), .out_valid(ov4), .out_ready(out_ready), .out_mode(om4),
        .out_data(od4), .occupancy(occ4));
    aes_shiftrows_unit #(.NB(6)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy6), .in_mode(in_mode),
        .in_data(in_d6), .out_valid(ov6), .out_ready(out_ready), .out_mode(om6),
        .out_data(od6), .occupancy(occ6));
    aes_shiftrows_unit #(.NB(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_mode(in_mode),
        .in_data(in_d8), .out_valid(ov8), .out_ready(out_ready), .out_mode(om8),
        .out_data(od8), .occupancy(occ8));

    always #5 clk = ~clk;

    // Reference: unpack to a 4xNb byte grid, rotate each row by its offset.
    function automatic logic [255:0] perm(input int nb, input bit inv, input logic [255:0] d);
        logic [7:0]   st[4][8];
        logic [255:0] o;
        int           sh[4];
        int           bw;
        int           src;
        bw = 32 * nb;
        o  = '0;
        sh[0] = 0;
        sh[1] = 1;
        sh[2] = (nb == 8) ? 3 : 2;
        sh[3] = (nb == 8) ? 4 : 3;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = d[bw-1-8*(4*c+r) -: 8];
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
                o[bw-1-8*(4*c+r) -: 8] = st[r][src];
            end
        return o;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a block until accepted; expected response enters the scoreboard
    // in the cycle the handshake completes.
    task automatic send(input bit m, input logic [255:0] d4, input logic [255:0] d6,
                        input logic [255:0] d8, input bit use_exp, input logic [255:0] x4,
                        input logic [255:0] x6, input logic [255:0] x8);
        exp_t e;
        int   n;
        bit   ok;
        in_valid = 1'b1;
        in_mode  = m;
        in_d4    = d4[127:0];
        in_d6    = d6[191:0];
        in_d8    = d8;
        e.mode   = m;
        e.e4     = use_exp ? x4 : perm(4, m, {128'b0, d4[127:0]});
        e.e6     = use_exp ? x6 : perm(6, m, {64'b0, d6[191:0]});
        e.e8     = use_exp ? x8 : perm(8, m, d8);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (rdy4 && !rst) begin
                ok = 1'b1;
                sb.push_back(e);
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
    endtask

    task automatic send_d(input bit m, input logic [255:0] d);
        send(m, d, d, d, 1'b0, '0, '0, '0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || occ4 != 2'd0) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_occupancy", occ4, 0);
        chk("drain_scoreboard", sb.size(), 0);
    endtask

    // Downstream ready: 0 = always ready, 1 = stalled, otherwise random.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reset discards everything buffered.
    always @(negedge clk) begin
        if (rst) sb.delete();
    end

    // Monitor: every delivered block is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && ov4 && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0h required=none", od4);
            end else begin
                mon_e = sb.pop_front();
                chk("valid6", ov6, 1);
                chk("valid8", ov8, 1);
                chk("mode4", om4, mon_e.mode);
                chk("mode6", om6, mon_e.mode);
                chk("mode8", om8, mon_e.mode);
                chk("data4", od4, mon_e.e4);
                chk("data6", od6, mon_e.e6);
                chk("data8", od8, mon_e.e8);
                if (cap_en) begin
                    cap4.push_back({128'b0, od4});
                    cap6.push_back({64'b0, od6});
                    cap8.push_back(od8);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [255:0] d, a, b, cblk, fa;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_d4    = '0;
        in_d6    = '0;
        in_d8    = '0;
        rmode    = 0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("reset_out_valid", ov4, 0);
        chk("reset_occupancy", occ4, 0);
        chk("reset_in_ready", rdy4, 1);
        chk("reset_out_data4", od4, 0);
        chk("reset_out_data8", od8, 0);
        chk("reset_out_mode", om4, 0);

        // FIPS-197 forward vector, 1-cycle latency
        send_d(1'b0, {128'b0, 128'hd42711aee0bf98f1b8b45de51e415230});
        chk("t1_valid", ov4, 1);
        chk("t1_data", od4, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        chk("t1_mode", om4, 0);
        // Inverse vector
        send_d(1'b1, {128'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
        chk("t2_data", od4, 128'hd42711aee0bf98f1b8b45de51e415230);
        chk("t2_mode", om4, 1);
        // NB=8 counting pattern
        for (int k = 0; k < 32; k++) d[255-8*k -: 8] = 8'(k);
        send_d(1'b0, d);
        chk("t3_r2c0", od8[255-8*2 -: 8], 8'h0e);
        chk("t3_r3c0", od8[255-8*3 -: 8], 8'h13);
        chk("t3_r3c7", od8[255-8*31 -: 8], 8'h0f);
        drain();

        // Backpressure: A, B fill the buffer, C is held off
        rmode = 1;
        tick();
        a = rnd256();
        b = rnd256();
        cblk = rnd256();
        fa = perm(4, 1'b0, {128'b0, a[127:0]});
        send_d(1'b0, a);
        send_d(1'b1, b);
        chk("bp_occupancy", occ4, 2);
        chk("bp_in_ready", rdy4, 0);
        chk("bp_head", od4, fa);
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_d4    = cblk[127:0];
        repeat (3) tick();
        chk("bp_hold_ready", rdy4, 0);
        chk("bp_hold_head", od4, fa);
        chk("bp_hold_mode", om4, 0);
        rmode = 0;
        send_d(1'b0, cblk);
        drain();

        // Simultaneous push/pop at occupancy 1, alternating modes
        for (int i = 0; i < 4; i++) begin
            send_d(1'(i % 2), rnd256());
            chk("pp_occupancy", occ4, 1);
            chk("pp_valid", ov4, 1);
        end
        drain();

        // Mid-stream reset with a full buffer and a pending input
        rmode = 1;
        tick();
        send_d(1'b0, rnd256());
        send_d(1'b1, rnd256());
        chk("rs_pre_occupancy", occ4, 2);
        in_valid = 1'b1;
        in_d4    = 128'h1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rs_out_valid", ov4, 0);
        chk("rs_occupancy", occ4, 0);
        chk("rs_in_ready", rdy4, 1);
        chk("rs_out_data4", od4, 0);
        chk("rs_out_data8", od8, 0);
        chk("rs_out_mode", om4, 0);
        rmode = 0;
        repeat (6) tick();
        chk("rs_no_stale", ov4, 0);

        // Random traffic with random backpressure and mixed modes
        rmode = 2;
        for (int i = 0; i < 300; i++) send_d(1'($urandom_range(0, 1)), rnd256());
        drain();

        // Round trip: forward 1000 blocks, feed results back through inverse
        cap_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            d = rnd256();
            origq.push_back(d);
            send_d(1'b0, d);
        end
        drain();
        cap_en = 1'b0;
        chk("rt_captured", cap4.size(), 1000);
        for (int i = 0; i < 1000 && i < cap4.size(); i++) begin
            d = origq[i];
            send(1'b1, cap4[i], cap6[i], cap8[i], 1'b1,
                 {128'b0, d[127:0]}, {64'b0, d[191:0]}, d);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_shiftrows_unit.md
Name: aes_shiftrows_unit

Overview:
Parametrised, handshaked ShiftRows / InvShiftRows stage for the AES/Rijndael datapath. It supports block widths of Nb = 4, 6 or 8 columns. The direction (forward or inverse) is selectable per block, so the encrypt and decrypt round pipelines share one unit. A registered 2-entry output buffer gives 1-cycle latency, full throughput and lossless backpressure.

Parameters:
NB, 4, number of state columns; legal values 4, 6, 8; any other value is an elaboration error.
BW, 32*NB, block width in bits; derived, must not be overridden.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
in_valid  in  1  input block valid.
in_ready  out  1  unit can accept a block this cycle.
in_mode  in  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt); sampled with the block.
in_data  in  BW  input state.
out_valid  out  1  output block valid.
out_ready  in  1  downstream accepts.
out_mode  out  1  mode the head block was processed with.
out_data  out  BW  permuted state.
occupancy  out  2  number of buffered blocks, 0..2.

Behaviour:
- Byte mapping (column-major, MSB first): byte (r,c), with r in 0..3 and c in 0..NB-1, sits at bits [BW-1-8*(4c+r) -: 8], for both in_data and out_data.
- Row shift offsets s_r:
  - NB=4 or 6: s = {0,1,2,3}.
  - NB=8: s = {0,1,3,4}.
- Forward permutation: out(r,c) = in(r,(c+s_r) mod NB).
- Inverse permutation: out(r,c) = in(r,(c-s_r) mod NB). Wrap-around is modulo NB, not modulo 4.
- Permutation is combinational on in_data and is written into the buffer at accept. No arithmetic is performed; the data path is pure byte routing plus storage.
- Accept: the input is accepted when in_valid && in_ready.
- Pop: a buffer entry is popped when out_valid && out_ready.
- Buffer: 2-entry FIFO of {mode, data}.
  - in_ready = (occupancy < 2), driven from a register; no combinational path from out_ready.
  - out_valid = (occupancy != 0).
  - out_data and out_mode show the head entry.
- Latency: a block accepted at edge N is on out_data with out_valid=1 after edge N (visible in cycle N+1). There is no bypass path.
- Occupancy transitions per edge:
  - Accept only: +1.
  - Pop only: -1.
  - Accept and pop together: unchanged. With occupancy=1, the new block becomes head after the current head leaves.
  - occupancy=2: in_ready=0, so no accept can occur. A pop in that cycle makes occupancy=1 and in_ready=1 in the next cycle.
- Stability: while out_valid=1 and out_ready=0, out_data and out_mode hold stable, and the head entry is not overwritten.
- in_valid while in_ready=0: ignored; the source must hold its data.
- Mode mixing: blocks of both modes may be interleaved freely; each block carries its own mode through the buffer.
- Reset (synchronous, rst=1 at an edge):
  - occupancy=0, out_valid=0, in_ready=1 after the edge.
  - out_data=0, out_mode=0.
  - Buffered blocks are discarded, including during a mid-stream reset.
  - An in_valid asserted in the reset cycle is not accepted.
- Steady state: with out_ready held at 1, the unit sustains 1 block/cycle.

Test Plan:
1. NB=4, mode=0, in_data=d42711aee0bf98f1b8b45de51e415230, out_ready=1 -> next cycle out_valid=1, out_data=d4bf5d30e0b452aeb84111f11e2798e5, out_mode=0.
2. NB=4, mode=1, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=d42711aee0bf98f1b8b45de51e415230, out_mode=1. Then a forward-then-inverse round-trip of 1000 random blocks must return the original data, for NB=4, 6 and 8.
3. NB=8, mode=0, in_data = bytes 00..1f in column-major order -> row 2 shifted by 3 and row 3 by 4. Example: out(2,0)=in(2,3)=0e, out(3,0)=in(3,4)=13, out(3,7)=in(3,3)=0f. Checked against a scoreboard model.
4. Backpressure: out_ready=0, push blocks A, B -> occupancy=2, in_ready=0, C held off and out_data=f(A) stable. Then out_ready=1 -> A, B, C delivered in order with no loss or duplicates, and occupancy returns to 0.
5. Simultaneous push/pop at occupancy=1, alternating modes 0/1/0 with out_ready=1 -> occupancy stays 1, one block per cycle, and each out_mode matches its block.
6. Reset mid-stream with occupancy=2 and in_valid=1 -> the cycle after reset: out_valid=0, occupancy=0, in_ready=1, out_data=0, and no stale block is emitted afterward.
